// File: rtl/mod_reg_dump.sv
// Register-range dump engine: walks [first, last] through a combinational
// register-file read port and streams (addr, data) words on valid/ready.
module mod_reg_dump #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned REG_FILE_SZ    = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic [REG_ADDR_WIDTH-1:0] first_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] last_addr_i,
  input  logic                      abort_i,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [XLEN-1:0]           rd_data_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [REG_ADDR_WIDTH-1:0] out_addr_o,
  output logic [XLEN-1:0]           out_data_o,
  output logic                      busy_o,
  output logic                      done_o
);

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_e;

  if (REG_FILE_SZ > (1 << REG_ADDR_WIDTH)) begin : g_cfg_check
    $error("REG_FILE_SZ does not fit in REG_ADDR_WIDTH");
  end

  state_e                    state_q, state_d;
  logic [REG_ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [REG_ADDR_WIDTH-1:0] last_q, last_d;
  logic                      out_valid_q, out_valid_d;
  logic [REG_ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [XLEN-1:0]           out_data_q, out_data_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      last_q      <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          last_d  = last_addr_i;
          ptr_d   = first_addr_i;
          state_d = (first_addr_i > last_addr_i) ? DONE : READ;
        end
      end
      READ: begin
        out_data_d  = rd_data_i;
        out_addr_d  = ptr_q;
        ptr_d       = ptr_q + REG_ADDR_WIDTH'(1);
        out_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        if (out_valid_q && out_ready_i) begin
          if (out_addr_q == last_q) begin
            out_valid_d = 1'b0;
            state_d     = DONE;
          end else begin
            // Refill in the handshake cycle so words go out back-to-back.
            out_data_d = rd_data_i;
            out_addr_d = ptr_q;
            ptr_d      = ptr_q + REG_ADDR_WIDTH'(1);
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_i && (state_q != IDLE)) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    rd_addr_o   = ptr_q;
    out_valid_o = out_valid_q;
    out_addr_o  = out_addr_q;
    out_data_o  = out_data_q;
    busy_o      = (state_q != IDLE);
    done_o      = (state_q == DONE);
  end

endmodule

// File: tb/tb_mod_reg_dump.sv
// Scoreboard bench for mod_reg_dump: a small register-file model feeds the
// read port, expected words are queued at start and popped on handshakes.
module tb_mod_reg_dump;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  first_addr;
  logic [4:0]  last_addr;
  logic        abort;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        busy;
  logic        done;

  logic [31:0] rf [32];
  word_t       sb_q [$];
  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;
  int unsigned done_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [4:0]  prev_addr;
  logic [31:0] prev_data;

  always #5 clk = ~clk;

  assign rd_data = (rd_addr == 5'd0) ? 32'd0 : rf[rd_addr];

  mod_reg_dump #(
    .XLEN(32),
    .REG_ADDR_WIDTH(5),
    .REG_FILE_SZ(32)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .start_i(start),
    .first_addr_i(first_addr),
    .last_addr_i(last_addr),
    .abort_i(abort),
    .rd_addr_o(rd_addr),
    .rd_data_i(rd_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_addr_o(out_addr),
    .out_data_o(out_data),
    .busy_o(busy),
    .done_o(done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_val(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : rf[a];
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (out_valid && prev_stall) begin
        check("hold_addr", 64'(out_addr), 64'(prev_addr));
        check("hold_data", 64'(out_data), 64'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_word", 64'(out_addr), 64'h1_0000_0000);
        end else begin
          word_t w;
          w = sb_q.pop_front();
          check("word_addr", 64'(out_addr), 64'(w.a));
          check("word_data", 64'(out_data), 64'(w.d));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_addr  = out_addr;
      prev_data  = out_data;
      if (done) done_cnt++;
    end
  end

  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input bit bp, input bit wr4);
    int unsigned k;
    int unsigned exp_lat;
    bit seen;
    for (int a = int'(f); a <= int'(l); a++) sb_q.push_back({5'(a), exp_val(5'(a))});
    exp_lat = (f > l) ? 0 : (int'(l) - int'(f) + 2);
    @(posedge clk); #1;
    first_addr = f; last_addr = l; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; seen = 1'b0;
    while (!seen && k < 200) begin
      out_ready = bp ? (k % 3 == 0) : 1'b1;
      @(negedge clk);
      if (k == 0) check("busy_after_start", 64'(busy), 64'd1);
      if (done) begin
        seen = 1'b1;
        check("busy_in_done", 64'(busy), 64'd1);
        if (!bp) check("done_latency", 64'(k), 64'(exp_lat));
      end
      @(posedge clk);
      if (wr4 && k == 0) rf[4] <= 32'hDEAD;
      #1;
      k++;
    end
    if (!seen) begin
      check("done_timeout", 64'd0, 64'd1);
    end else begin
      @(negedge clk);
      check("done_one_cycle", 64'(done), 64'd0);
      check("idle_after_done", 64'(busy), 64'd0);
    end
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    out_ready = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] <= 32'h100 + 32'(i);
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    first_addr = '0; last_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rd_addr", 64'(rd_addr), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    rst_n = 1'b1;

    run_dump(5'd0, 5'd31, 1'b0, 1'b0);
    run_dump(5'd5, 5'd7, 1'b1, 1'b0);
    run_dump(5'd31, 5'd31, 1'b0, 1'b0);
    run_dump(5'd9, 5'd3, 1'b0, 1'b0);

    // Abort after two words; a stray start mid-dump must be ignored.
    sb_q.push_back({5'd0, 32'd0});
    sb_q.push_back({5'd1, 32'h101});
    @(posedge clk); #1;
    first_addr = 5'd0; last_addr = 5'd31; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; first_addr = 5'd3; last_addr = 5'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0; abort = 1'b1;
    @(negedge clk);
    check("abort_pre_valid", 64'(out_valid), 64'd1);
    check("abort_pre_addr", 64'(out_addr), 64'd2);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    check("abort_idle", 64'(busy), 64'd0);
    check("abort_words", 64'(sb_q.size()), 64'd0);
    out_ready = 1'b1;

    // Async reset while a word is stalled in SEND.
    @(posedge clk); #1;
    first_addr = 5'd5; last_addr = 5'd31; start = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_rd_addr", 64'(rd_addr), 64'd0);
    check("arst_out_addr", 64'(out_addr), 64'd0);
    check("arst_out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    run_dump(5'd2, 5'd2, 1'b0, 1'b0);

    run_dump(5'd4, 5'd4, 1'b0, 1'b1);
    run_dump(5'd4, 5'd4, 1'b0, 1'b0);

    check("done_count", 64'(done_cnt), 64'd7);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog");
  end

endmodule
